master_spi: RTL and testbench

- Single-clock SPI master that drives the team's register-access protocol from the host side.
- Converts a command (address, direction, burst length) plus parallel write words into `spi_clk`/`spi_cs_n`/`spi_mosi`, and returns read words captured from `spi_miso`.
- Pairs with `slave_spi`: mode 0 (`spi_clk` idles low), MSB first, 8-bit header then 16-bit data words, address auto-increment handled by the slave.
- Used on the host/test FPGA or in loopback benches against the register bank.

---
 rtl/master_spi.sv | 269 ++++++++++++++++++++++++++
 tb/tb_master_spi.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/master_spi.sv
// master_spi: single-clock SPI master for the register-access protocol.
//
// A command (address, read/write, burst length - 1) is turned into one
// chip-select framed transfer: an ALINES+1 bit header {addr, rd}, followed by
// cmd_len+1 data words of DWIDTH bits. Mode 0, MSB first. The slave handles
// address auto-increment; this block only counts words.
//
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   cmd_valid / cmd_ready     command handshake (cmd_ready high only in IDLE)
//   cmd_rd, cmd_addr, cmd_len burst direction, start address, length - 1
//   wdata, wdata_valid        write word source
//   wdata_ready               one-cycle pulse when a write word is taken
//   rdata, rdata_valid        read word and its one-cycle strobe
//   done                      pulse when spi_cs_n returns high
//   busy                      high from accept until cmd_ready reasserts
//   spi_clk, spi_cs_n,
//   spi_mosi, spi_miso        SPI bus (outputs registered)
module master_spi #(
    parameter int DWIDTH   = 16,
    parameter int ALINES   = 7,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rd,
    input  logic [ALINES-1:0] cmd_addr,
    input  logic [ALINES-1:0] cmd_len,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic [DWIDTH-1:0] rdata,
    output logic              rdata_valid,
    output logic              done,
    output logic              busy,
    output logic              spi_clk,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int HW   = ALINES + 1;
    localparam int CMAX = (CLK_DIV > CS_SETUP)
                        ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                        : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(DWIDTH + 1);

    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
    localparam logic [BW-1:0] HDR_BITS   = BW'(HW);
    localparam logic [BW-1:0] WORD_BITS  = BW'(DWIDTH);
    localparam logic [BW-1:0] WORD_LAST  = BW'(DWIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HEADER,
        DATA,
        WSTALL,
        HOLD,
        GAP
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]     cnt, cnt_nx;         // half-period / setup / hold / gap timer
    logic [BW-1:0]     bit_cnt, bit_nx;     // rising edges seen in the current field
    logic [ALINES:0]   word_cnt, word_nx;   // index of the word on the wire
    logic              rd_q, rd_nx;
    logic [ALINES-1:0] len_q, len_nx;
    logic [DWIDTH-1:0] sh, sh_nx;           // outgoing bits, current bit at MSB
    logic [DWIDTH-1:0] wbuf, wbuf_nx;       // word 0, taken at accept
    logic [DWIDTH-2:0] rx_sh, rx_sh_nx;     // read bits gathered so far
    logic [DWIDTH-1:0] rx_word;
    logic              clk_nx, cs_n_nx, mosi_nx;
    logic [DWIDTH-1:0] rdata_nx;
    logic              rdata_valid_nx, done_nx;
    logic              take_word;

    assign cmd_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    // Combinational so the word is acknowledged in the cycle it is consumed;
    // masked during reset so an aborted transfer never acknowledges a word.
    assign wdata_ready = take_word & ~rst;

    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        bit_nx         = bit_cnt;
        word_nx        = word_cnt;
        rd_nx          = rd_q;
        len_nx         = len_q;
        sh_nx          = sh;
        wbuf_nx        = wbuf;
        rx_sh_nx       = rx_sh;
        rx_word        = {rx_sh, spi_miso};
        clk_nx         = spi_clk;
        cs_n_nx        = spi_cs_n;
        mosi_nx        = spi_mosi;
        rdata_nx       = rdata;
        rdata_valid_nx = 1'b0;
        done_nx        = 1'b0;
        take_word      = 1'b0;

        case (state)
            IDLE: begin
                // A write is only accepted together with its first word.
                if (cmd_valid && (cmd_rd || wdata_valid)) begin
                    rd_nx     = cmd_rd;
                    len_nx    = cmd_len;
                    wbuf_nx   = wdata;
                    take_word = ~cmd_rd;
                    sh_nx     = DWIDTH'({cmd_addr, cmd_rd}) << (DWIDTH - HW);
                    mosi_nx   = cmd_addr[ALINES-1];
                    cs_n_nx   = 1'b0;
                    cnt_nx    = '0;
                    bit_nx    = '0;
                    word_nx   = '0;
                    state_nx  = SETUP;
                end
            end

            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    clk_nx   = 1'b1;
                    bit_nx   = BW'(1);
                    cnt_nx   = '0;
                    state_nx = HEADER;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end

            HEADER, DATA: begin
                if (cnt != DIV_LAST) begin
                    cnt_nx = cnt + CW'(1);
                end else begin
                    cnt_nx = '0;
                    if (!spi_clk) begin
                        // Rising edge: the slave samples MOSI, we sample MISO.
                        clk_nx = 1'b1;
                        bit_nx = bit_cnt + BW'(1);
                        if (state == DATA && rd_q) begin
                            rx_sh_nx = rx_word[DWIDTH-2:0];
                            if (bit_cnt == WORD_LAST) begin
                                rdata_nx       = rx_word;
                                rdata_valid_nx = 1'b1;
                            end
                        end
                    end else begin
                        // Falling edge: present the next MOSI bit.
                        clk_nx = 1'b0;
                        if (state == HEADER) begin
                            if (bit_cnt == HDR_BITS) begin
                                bit_nx   = '0;
                                state_nx = DATA;
                                sh_nx    = rd_q ? '0 : wbuf;
                                mosi_nx  = rd_q ? 1'b0 : wbuf[DWIDTH-1];
                            end else begin
                                sh_nx   = sh << 1;
                                mosi_nx = sh[DWIDTH-2];
                            end
                        end else if (bit_cnt == WORD_BITS) begin
                            bit_nx = '0;
                            if (word_cnt == {1'b0, len_q}) begin
                                mosi_nx  = 1'b0;
                                state_nx = HOLD;
                            end else begin
                                word_nx = word_cnt + 1'b1;
                                if (rd_q) begin
                                    mosi_nx = 1'b0;
                                end else if (wdata_valid) begin
                                    take_word = 1'b1;
                                    sh_nx     = wdata;
                                    mosi_nx   = wdata[DWIDTH-1];
                                end else begin
                                    mosi_nx  = 1'b0;
                                    state_nx = WSTALL;
                                end
                            end
                        end else begin
                            sh_nx   = sh << 1;
                            mosi_nx = sh[DWIDTH-2];
                        end
                    end
                end
            end

            WSTALL: begin
                // spi_clk is already low; the timer is preset to 1 so the
                // next rise lands CLK_DIV cycles after the word arrives.
                if (wdata_valid) begin
                    take_word = 1'b1;
                    sh_nx     = wdata;
                    mosi_nx   = wdata[DWIDTH-1];
                    cnt_nx    = CW'(1);
                    state_nx  = DATA;
                end
            end

            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cs_n_nx  = 1'b1;
                    done_nx  = 1'b1;
                    cnt_nx   = '0;
                    state_nx = GAP;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end

            GAP: begin
                if (cnt == DIV_LAST) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            rd_q        <= 1'b0;
            len_q       <= '0;
            sh          <= '0;
            wbuf        <= '0;
            rx_sh       <= '0;
            spi_clk     <= 1'b0;
            spi_cs_n    <= 1'b1;
            spi_mosi    <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            bit_cnt     <= bit_nx;
            word_cnt    <= word_nx;
            rd_q        <= rd_nx;
            len_q       <= len_nx;
            sh          <= sh_nx;
            wbuf        <= wbuf_nx;
            rx_sh       <= rx_sh_nx;
            spi_clk     <= clk_nx;
            spi_cs_n    <= cs_n_nx;
            spi_mosi    <= mosi_nx;
            rdata       <= rdata_nx;
            rdata_valid <= rdata_valid_nx;
            done        <= done_nx;
        end
    end

endmodule

// File: tb/tb_master_spi.sv
// tb_master_spi: directed bench for master_spi with a behavioural SPI slave
// (header decode, write-word log, read memory driven on falling edges).
`timescale 1ns/1ps
module tb_master_spi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rd = 1'b0;
    logic [6:0]  cmd_addr = '0;
    logic [6:0]  cmd_len = '0;
    logic [15:0] wdata = '0;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic        done;
    logic        busy;
    logic        spi_clk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    master_spi #(
        .DWIDTH  (16),
        .ALINES  (7),
        .CLK_DIV (2),
        .CS_SETUP(2),
        .CS_HOLD (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rd     (cmd_rd),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .wdata      (wdata),
        .wdata_valid(wdata_valid),
        .wdata_ready(wdata_ready),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .done       (done),
        .busy       (busy),
        .spi_clk    (spi_clk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- write word source ----------------
    logic [15:0] wq[$];
    logic        take;

    always @(posedge clk) begin
        take = wdata_ready;
        #1;
        if (take === 1'b1 && wq.size() > 0) void'(wq.pop_front());
        wdata_valid = (wq.size() > 0);
        wdata       = (wq.size() > 0) ? wq[0] : 16'h0000;
    end

    // ---------------- slave model and monitor ----------------
    logic [15:0]  mem [128];
    logic [15:0]  rq[$];
    logic [6:0]   la[$];
    logic [15:0]  ld[$];
    logic [15:0]  s_sh = '0;
    int unsigned  s_bits = 0;
    logic [6:0]   s_addr = '0;
    logic         s_rd = 1'b0;
    logic [7:0]   last_hdr = '0;
    logic [15:0]  s_word;
    int unsigned  s_idx, s_wi;
    logic         prev_sclk = 1'b0;
    logic         prev_ready = 1'b1;
    int unsigned  rise_cnt, done_cnt, wtake_cnt, ready_cs_bad, cs_run, min_gap;
    bit           had_low;
    time          first_rise_t, last_fall_t, done_t, ready_t;

    task automatic clear_stats();
        rise_cnt = 0; done_cnt = 0; wtake_cnt = 0; ready_cs_bad = 0;
        cs_run = 0; min_gap = 999; had_low = 1'b0;
        first_rise_t = 0; last_fall_t = 0; done_t = 0; ready_t = 0;
        rq.delete(); la.delete(); ld.delete();
        last_hdr = '0;
    endtask

    always @(negedge clk) begin
        if (spi_cs_n !== 1'b0) begin
            s_bits   = 0;
            spi_miso = 1'b0;
        end else begin
            if (!prev_sclk && spi_clk === 1'b1) begin
                s_sh = {s_sh[14:0], spi_mosi};
                s_bits++;
                if (s_bits == 8) begin
                    last_hdr = s_sh[7:0];
                    s_addr   = s_sh[7:1];
                    s_rd     = s_sh[0];
                end else if (s_bits > 8 && (s_bits - 8) % 16 == 0 && !s_rd) begin
                    la.push_back(7'(s_addr + 7'((s_bits - 8) / 16 - 1)));
                    ld.push_back(s_sh);
                end
            end
            if (prev_sclk && spi_clk === 1'b0 && s_bits >= 8 && s_rd) begin
                s_idx    = (s_bits - 8) % 16;
                s_wi     = (s_bits - 8) / 16;
                s_word   = mem[7'(s_addr + 7'(s_wi))];
                spi_miso = s_word[15 - s_idx];
            end
        end

        if (!prev_sclk && spi_clk === 1'b1) begin
            rise_cnt++;
            if (first_rise_t == 0) first_rise_t = $time;
        end
        if (prev_sclk && spi_clk === 1'b0) last_fall_t = $time;
        if (done === 1'b1) begin done_cnt++; done_t = $time; end
        if (wdata_ready === 1'b1) wtake_cnt++;
        if (rdata_valid === 1'b1) rq.push_back(rdata);
        if (!prev_ready && cmd_ready === 1'b1) ready_t = $time;
        if (cmd_ready === 1'b1 && spi_cs_n === 1'b0) ready_cs_bad++;
        if (spi_cs_n === 1'b1) cs_run++;
        else begin
            if (cs_run > 0 && had_low && cs_run < min_gap) min_gap = cs_run;
            cs_run  = 0;
            had_low = 1'b1;
        end
        prev_sclk  = (spi_clk === 1'b1);
        prev_ready = (cmd_ready === 1'b1);
    end

    // ---------------- helpers ----------------
    function automatic int cyc_of(input time t, input time t0);
        return int'((t - t0 - 5) / 10) + 1;
    endfunction

    task automatic do_cmd(input logic rd, input logic [6:0] addr, input logic [6:0] len,
                          output time t_acc);
        int unsigned n = 0;
        bit ok = 1'b0;
        cmd_rd = rd; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
        while (!ok && n < 200) begin
            @(posedge clk);
            if (cmd_valid && cmd_ready === 1'b1 && (cmd_rd || wdata_valid)) ok = 1'b1;
            n++;
        end
        t_acc = $time;
        #1 cmd_valid = 1'b0;
        check("accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
        check(tag, {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_rises(input string tag, input int unsigned target);
        int unsigned n = 0;
        bit ok = 1'b0;
        while (!ok && n < 2000) begin
            @(negedge clk); #1;
            if (rise_cnt == target && spi_clk === 1'b0) ok = 1'b1;
            n++;
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        time t0;
        int unsigned bad, acc, n;

        for (int i = 0; i < 128; i++) mem[i] = 16'(i * 16'h0101) ^ 16'h3C5A;
        mem[16'h10] = 16'h1234;
        mem[16'h11] = 16'hBEEF;
        clear_stats();

        // reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctl", {24'd0, spi_cs_n, spi_clk, spi_mosi, cmd_ready, wdata_ready,
                            rdata_valid, done, busy}, 32'b1001_0000);
        check("reset_rdata", {16'd0, rdata}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // single write 0x05 <- 0xA5C3
        clear_stats();
        wq.push_back(16'hA5C3);
        @(posedge clk); #1;
        do_cmd(1'b0, 7'h05, 7'd0, t0);
        check("w1_wready_accept", 32'(wtake_cnt), 32'd1);
        @(negedge clk);
        check("w1_cycle1", {28'd0, spi_cs_n, busy, cmd_ready, spi_mosi}, 32'b0100);
        wait_idle("w1_idle");
        check("w1_first_rise", 32'(cyc_of(first_rise_t, t0)), 32'd3);
        check("w1_last_fall", 32'(cyc_of(last_fall_t, t0)), 32'd97);
        check("w1_done_cycle", 32'(cyc_of(done_t, t0)), 32'd99);
        check("w1_ready_cycle", 32'(cyc_of(ready_t, t0)), 32'd101);
        check("w1_rises", 32'(rise_cnt), 32'd24);
        check("w1_dones", 32'(done_cnt), 32'd1);
        check("w1_header", {24'd0, last_hdr}, 32'h0A);
        check("w1_nwords", 32'(la.size()), 32'd1);
        if (la.size() > 0) begin
            check("w1_addr", {25'd0, la[0]}, 32'h05);
            check("w1_data", {16'd0, ld[0]}, 32'hA5C3);
        end

        // read burst 0x10, 2 words
        clear_stats();
        do_cmd(1'b1, 7'h10, 7'd1, t0);
        wait_idle("r2_idle");
        check("r2_header", {24'd0, last_hdr}, 32'h21);
        check("r2_count", 32'(rq.size()), 32'd2);
        if (rq.size() == 2) begin
            check("r2_word0", {16'd0, rq[0]}, 32'h1234);
            check("r2_word1", {16'd0, rq[1]}, 32'hBEEF);
        end
        check("r2_rises", 32'(rise_cnt), 32'd40);
        check("r2_dones", 32'(done_cnt), 32'd1);
        check("r2_wready", 32'(wtake_cnt), 32'd0);

        // write with a stall before word 1
        clear_stats();
        wq.push_back(16'hC001);
        @(posedge clk); #1;
        do_cmd(1'b0, 7'h30, 7'd2, t0);
        wait_rises("ws_reach_stall", 24);
        bad = 0;
        repeat (37) begin
            @(negedge clk); #1;
            if (spi_clk !== 1'b0 || spi_cs_n !== 1'b0 || busy !== 1'b1 || rise_cnt != 24) bad++;
        end
        check("ws_stall_hold", 32'(bad), 32'd0);
        wq.push_back(16'h0DD5);
        wq.push_back(16'h7E57);
        wait_idle("ws_idle");
        check("ws_wready", 32'(wtake_cnt), 32'd3);
        check("ws_rises", 32'(rise_cnt), 32'd56);
        check("ws_dones", 32'(done_cnt), 32'd1);
        check("ws_nwords", 32'(la.size()), 32'd3);
        if (la.size() == 3) begin
            check("ws_a0", {25'd0, la[0]}, 32'h30);
            check("ws_a1", {25'd0, la[1]}, 32'h31);
            check("ws_a2", {25'd0, la[2]}, 32'h32);
            check("ws_d0", {16'd0, ld[0]}, 32'hC001);
            check("ws_d1", {16'd0, ld[1]}, 32'h0DD5);
            check("ws_d2", {16'd0, ld[2]}, 32'h7E57);
        end

        // max read burst
        clear_stats();
        do_cmd(1'b1, 7'h00, 7'd127, t0);
        wait_idle("mx_idle");
        check("mx_count", 32'(rq.size()), 32'd128);
        check("mx_rises", 32'(rise_cnt), 32'd2056);
        check("mx_dones", 32'(done_cnt), 32'd1);
        bad = 0;
        for (int i = 0; i < rq.size() && i < 128; i++) if (rq[i] !== mem[i]) bad++;
        check("mx_data", 32'(bad), 32'd0);

        // reset during bit 9 of word 0
        clear_stats();
        wq.push_back(16'h1111); wq.push_back(16'h2222);
        wq.push_back(16'h3333); wq.push_back(16'h4444);
        @(posedge clk); #1;
        do_cmd(1'b0, 7'h08, 7'd3, t0);
        wait_rises("rm_reach_bit9", 17);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rm_ctl", {24'd0, spi_cs_n, spi_clk, spi_mosi, cmd_ready, wdata_ready,
                         rdata_valid, done, busy}, 32'b1001_0000);
        check("rm_rdata", {16'd0, rdata}, 32'd0);
        wq.delete();
        repeat (4) @(posedge clk); #1;
        check("rm_dones", 32'(done_cnt), 32'd0);
        check("rm_wready", 32'(wtake_cnt), 32'd1);
        check("rm_nwords", 32'(la.size()), 32'd0);
        check("rm_rvalid", 32'(rq.size()), 32'd0);
        clear_stats();
        wq.push_back(16'h0F0F);
        @(posedge clk); #1;
        do_cmd(1'b0, 7'h20, 7'd0, t0);
        wait_idle("rm_after_idle");
        check("rm_after_nwords", 32'(la.size()), 32'd1);
        if (la.size() > 0) begin
            check("rm_after_addr", {25'd0, la[0]}, 32'h20);
            check("rm_after_data", {16'd0, ld[0]}, 32'h0F0F);
        end
        check("rm_after_dones", 32'(done_cnt), 32'd1);

        // back-to-back reads with cmd_valid held high
        clear_stats();
        cmd_rd = 1'b1; cmd_addr = 7'h40; cmd_len = 7'd0; cmd_valid = 1'b1;
        acc = 0; n = 0;
        while (acc < 2 && n < 2000) begin
            @(posedge clk);
            if (cmd_valid && cmd_ready === 1'b1) acc++;
            n++;
        end
        #1 cmd_valid = 1'b0;
        wait_idle("bb_idle");
        check("bb_accepts", 32'(acc), 32'd2);
        check("bb_dones", 32'(done_cnt), 32'd2);
        check("bb_min_gap", 32'(min_gap), 32'd3);
        check("bb_ready_in_cs", 32'(ready_cs_bad), 32'd0);
        check("bb_rvalid", 32'(rq.size()), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
